// File: rtl/fir_ctrl_pkg.sv
// Shared types and width helpers for the FIR coefficient controller.
// Imported by the controller, the coefficient bank and the bench.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } fir_ctrl_state_t;

    // The index must be able to hold NUM_COEFFS itself, one past the last tap
    function automatic int idx_width(input int num_coeffs);
        return $clog2(num_coeffs + 1);
    endfunction

    // A single-tap filter has nothing to settle, but the counter still needs one bit
    function automatic int settle_width(input int num_coeffs);
        return (num_coeffs > 1) ? $clog2(num_coeffs) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Load/commit bus between the coefficient source, the FIR and fir_coeff_ctrl.
// The master drives the coefficient stream; the slave is the controller.
interface fir_coeff_ctrl_if #(
    parameter int NUM_COEFFS  = 64,
    parameter int COEFF_WIDTH = 16
);
    logic                                load_start;
    logic signed [COEFF_WIDTH-1:0]       coeff_wr_data;
    logic                                coeff_wr_valid;
    logic                                coeff_wr_ready;
    logic                                sample_tick;
    logic [NUM_COEFFS*COEFF_WIDTH-1:0]   coeffs;
    logic                                armed;
    logic                                swap_pulse;
    logic                                settling;

    modport master (
        output load_start, coeff_wr_data, coeff_wr_valid, sample_tick,
        input  coeff_wr_ready, coeffs, armed, swap_pulse, settling
    );

    modport slave (
        input  load_start, coeff_wr_data, coeff_wr_valid, sample_tick,
        output coeff_wr_ready, coeffs, armed, swap_pulse, settling
    );
endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient register arrays for the FIR.
// The shadow bank takes single-tap writes; the active bank copies it whole on swap.
module fir_coeff_bank #(
    parameter int NUM_COEFFS  = 64,
    parameter int COEFF_WIDTH = 16,
    parameter int IDX_W       = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic signed [COEFF_WIDTH-1:0]     wr_data,
    input  logic                              swap,
    output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs
);

    logic signed [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] shadow_d [NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] active_q [NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] active_d [NUM_COEFFS];

    // Swap copies the shadow as it stood before this cycle's write, if any
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NUM_COEFFS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
        if (swap) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        coeffs = '0;
        for (int i = 0; i < NUM_COEFFS; i++) begin
            coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[i];
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient load controller: streams taps into a shadow bank, commits them on a
// sample boundary and flags the window where the FIR pipeline still holds old products.
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_COEFFS  = 64,
    parameter int COEFF_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    fir_coeff_ctrl_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_COEFFS);
    localparam int SET_W = settle_width(NUM_COEFFS);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_COEFFS - 1);
    localparam logic [SET_W-1:0] SETTLE_RELOAD = SET_W'(NUM_COEFFS - 1);

    fir_ctrl_state_t   state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              swap_pulse_q, swap_pulse_d;
    logic              settling_q, settling_d;
    logic              bank_we;
    logic              bank_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            swap_pulse_q <= 1'b0;
            settling_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            swap_pulse_q <= swap_pulse_d;
            settling_q   <= settling_d;
        end
    end

    // A restart beats a coincident write; a tick in ARMED beats a coincident restart
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bank_we   = 1'b0;
        bank_swap = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    idx_d = '0;
                end else if (bus.coeff_wr_valid) begin
                    bank_we = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (bus.sample_tick) begin
                    bank_swap = 1'b1;
                    state_d   = IDLE;
                end else if (bus.load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Products computed with old taps drain out over NUM_COEFFS-1 further samples
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        swap_pulse_d = bank_swap;
        if (bank_swap) begin
            settle_cnt_d = SETTLE_RELOAD;
        end else if (bus.sample_tick && (settle_cnt_q != '0)) begin
            settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
        settling_d = (settle_cnt_d != '0);
    end

    fir_coeff_bank #(
        .NUM_COEFFS  (NUM_COEFFS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we),
        .wr_idx  (idx_q),
        .wr_data (bus.coeff_wr_data),
        .swap    (bank_swap),
        .coeffs  (bus.coeffs)
    );

    assign bus.coeff_wr_ready = (state_q == LOAD);
    assign bus.armed          = (state_q == ARMED);
    assign bus.swap_pulse     = swap_pulse_q;
    assign bus.settling       = settling_q;

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Configuration controller for the audio FIR filter. It accepts a serial stream of coefficients into a shadow bank, then commits them atomically to the active bank that drives the FIR's packed coefficient bus. The commit happens only on a sample boundary, so the filter never runs a sample with a partially updated coefficient set. It then flags a settling window while the FIR's partial-sum pipeline still holds products computed with the old coefficients.

Parameters:
NUM_COEFFS, 64, number of taps; must match the FIR instance.
COEFF_WIDTH, 16, signed coefficient width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load_start  in  1  single-cycle pulse; begins (or restarts) a coefficient load
coeff_wr_data  in  COEFF_WIDTH  signed coefficient, tap 0 first
coeff_wr_valid  in  1  coeff_wr_data is valid
coeff_wr_ready  out  1  controller accepts a coefficient this cycle
sample_tick  in  1  same strobe that drives the FIR's data_in_valid
coeffs  out  NUM_COEFFS*COEFF_WIDTH  packed active bank; tap i is at bits [i*COEFF_WIDTH +: COEFF_WIDTH]
armed  out  1  full shadow bank is waiting for a sample boundary
swap_pulse  out  1  one-cycle pulse on the cycle the active bank updates
settling  out  1  FIR output is mixing old and new coefficients

Behaviour:
- Reset (one clk with rst=1):
  - state=IDLE; shadow and active banks all 0; coeffs=0.
  - coeff_wr_ready=0, armed=0, swap_pulse=0, settling=0.
  - Write index and settle counter cleared.
  - Reset mid-load or mid-settle discards everything, including the shadow bank.
- Write index width: $clog2(NUM_COEFFS+1). Settle counter width: $clog2(NUM_COEFFS).
- IDLE:
  - coeff_wr_ready=0; writes are ignored.
  - load_start -> LOAD with idx=0.
- LOAD:
  - coeff_wr_ready=1.
  - Each cycle with valid&&ready: shadow[idx]<=coeff_wr_data, idx++.
  - Accepting write number NUM_COEFFS (idx reaches NUM_COEFFS) -> ARMED on the next cycle. coeff_wr_ready drops in that same next cycle.
  - load_start in LOAD: idx<=0 and stay in LOAD. Partial data is overwritten. If load_start and a write coincide, load_start wins and the write is dropped.
- ARMED:
  - armed=1, coeff_wr_ready=0.
  - On a cycle with sample_tick=1: active<=shadow; swap_pulse=1 next cycle; state -> IDLE.
  - coeffs changes the cycle after the tick. The FIR therefore uses the old set for the tick sample and the new set from the following sample onward.
  - load_start in ARMED (no tick that cycle) -> LOAD with idx=0; the pending set is discarded.
  - If load_start and sample_tick coincide in ARMED, the swap wins and load_start is ignored.
- Last write and sample_tick in the same cycle: enter ARMED only. The swap waits for a later tick.
- Settling:
  - On swap, settle_cnt<=NUM_COEFFS-1.
  - Each subsequent sample_tick with settle_cnt>0 decrements it.
  - settling = (settle_cnt!=0), registered.
  - A new swap during settling reloads the counter.
  - NUM_COEFFS=1: settling never asserts.
  - Settling does not block a new LOAD.
- The active bank changes only at a swap; no other path writes it.

Decomposition:
- Package fir_ctrl_pkg holds:
  - enum logic [1:0] fir_ctrl_state_t {IDLE, LOAD, ARMED}.
  - Localparam helper for the index width.
- One natural sub-module: fir_coeff_bank. It holds the shadow and active register arrays, a write port (we, idx, data), a swap strobe, and the packed output.
- The FSM, index counter and settle counter stay in fir_coeff_ctrl.

Test Plan:
All scenarios use NUM_COEFFS=4 and COEFF_WIDTH=16.
1. Reset, then check outputs -> coeffs=0, ready=0, armed=0, settling=0.
2. load_start, then write 1,2,3,4 back-to-back -> ready=1 for 4 cycles then 0, armed=1. First sample_tick -> swap_pulse the next cycle; coeffs taps {0..3}={1,2,3,4} from that cycle; armed=0.
3. After the swap in test 2, issue 3 sample_ticks -> settling=1 from the cycle after the swap, clearing after the 3rd tick. A 4th tick leaves settling=0.
4. load_start, write 5,6, load_start again, write 9,10,11,12, tick -> coeffs={9,10,11,12}. Values 5 and 6 are never visible.
5. Load 7,7,7,7 with the 4th write coincident with sample_tick -> no swap that cycle; swap on the next tick only.
6. In ARMED, assert rst for 1 cycle, then tick -> coeffs remains 0, no swap_pulse, state IDLE. Writes with coeff_wr_valid=1 in IDLE -> ready=0, no change to coeffs.
